// File: rtl/serial_add_ctrl_pkg.sv
// Shared types and sizing helpers for the bit-serial adder controller.
// No logic of its own; FSM state encodings and counter width are defined here.
// Imported by the controller and any block that needs to decode its state.
package serial_add_ctrl_pkg;

  // FSM state encodings: IDLE=0, SHIFT=1, DONE=2
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Bit counter width: clog2(width), never narrower than one bit
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Handshake and operand/result bundle for the bit-serial adder controller.
// Pure wiring; no latency of its own.
// Requester drives start/operands; the controller accepts only while ready_out=1.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start_in;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             sub_in;
  logic             ready_out;
  logic             busy_out;
  logic             done_out;
  logic [WIDTH-1:0] sum_out;
  logic             car_out;

  // Requester side
  modport master (
    output start_in, a_in, b_in, sub_in,
    input  ready_out, busy_out, done_out, sum_out, car_out
  );

  // Controller side
  modport slave (
    input  start_in, a_in, b_in, sub_in,
    output ready_out, busy_out, done_out, sum_out, car_out
  );
endinterface

// File: rtl/serial_add_ctrl_fa_cell.sv
// One-bit full adder built from two half-adder stages and an OR.
// Purely combinational, zero cycles.
// No handshake; the controller presents one bit position per clock.
module serial_add_ctrl_fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  logic hs1_sum;
  logic hs1_car;
  logic hs2_car;

  // First half adder combines the operand bits, second folds in the carry
  assign hs1_sum = a ^ b;
  assign hs1_car = a & b;
  assign sum     = hs1_sum ^ cin;
  assign hs2_car = hs1_sum & cin;
  assign cout    = hs1_car | hs2_car;
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one shared full-adder cell, one bit per clock, LSB first.
// Latency: done_out in the cycle after edge E0+WIDTH; one op per WIDTH+2 cycles.
// Backpressure: ready_out=1 only in IDLE; start_in in SHIFT/DONE is ignored, not queued.
// Optional subtract path enabled by defining SERIAL_ADD_SUB_EN (sub_in ignored otherwise).
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  serial_add_ctrl_if.slave  bus
);
  localparam int               CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  state_t           state_nxt;
  logic             load;
  logic             step;
  logic             last_bit;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] sum_q;
  logic             car_q;

  logic             sub_req;
  logic [WIDTH-1:0] b_load;
  logic             fa_sum;
  logic             fa_cout;

`ifdef SERIAL_ADD_SUB_EN
  // Subtract as A + ~B + 1: invert B at load, seed the carry with 1
  assign sub_req = bus.sub_in;
`else
  logic unused_sub;
  assign unused_sub = bus.sub_in;
  assign sub_req    = 1'b0;
`endif

  assign b_load   = sub_req ? ~bus.b_in : bus.b_in;
  assign last_bit = (cnt == CNT_LAST);

  serial_add_ctrl_fa_cell u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // State register; reset aborts any operation in flight
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  // Next state and datapath strobes
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.start_in) begin
          load      = 1'b1;
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        step = 1'b1;
        if (last_bit) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operand/result shifting; sum and carry outputs only change on entry to DONE
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      car_q  <= 1'b0;
    end else if (load) begin
      a_sh   <= bus.a_in;
      b_sh   <= b_load;
      res_sh <= '0;
      carry  <= sub_req;
      cnt    <= '0;
    end else if (step) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      res_sh <= {fa_sum, res_sh[WIDTH-1:1]};
      carry  <= fa_cout;
      if (last_bit) begin
        sum_q <= {fa_sum, res_sh[WIDTH-1:1]};
        car_q <= fa_cout;
      end else begin
        cnt   <= cnt + CNT_ONE;
      end
    end
  end

  assign bus.ready_out = (state == ST_IDLE);
  assign bus.busy_out  = (state == ST_SHIFT);
  assign bus.done_out  = (state == ST_DONE);
  assign bus.sum_out   = sum_q;
  assign bus.car_out   = car_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl (WIDTH=8): directed ops, expected results queued at issue.
// A monitor pops the queue on every done_out pulse and checks sum, carry and timing.
// Covers reset state, carries, held start, mid-op reset and back-to-back throughput.
module tb_serial_add_ctrl;
  localparam int WIDTH = 8;

  logic clk_in   = 1'b0;
  logic rst_n_in = 1'b0;

  serial_add_ctrl_if #(.WIDTH(WIDTH)) bus ();

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .bus      (bus)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             car;
    int               cyc;
  } exp_t;

  exp_t             exp_q[$];
  exp_t             mon_e;
  int               checks   = 0;
  int               failures = 0;
  int               cyc      = 0;
  logic [WIDTH-1:0] last_sum = '0;
  logic             last_car = 1'b0;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest queued expectation
  always @(negedge clk_in) begin
    if (rst_n_in && bus.done_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=pulse required=none (cyc %0d)", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("sum_out", 32'(bus.sum_out), 32'(mon_e.sum));
        check("car_out", 32'(bus.car_out), 32'(mon_e.car));
        check("done_cycle", cyc, mon_e.cyc);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (bus.ready_out !== 1'b1 && n < 100) begin
      @(negedge clk_in);
      n++;
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout actual=%0b required=1", bus.ready_out);
    end
  endtask

  // Issue one op, check result hold during SHIFT and the ready-low window
  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sub,
                       input logic [WIDTH-1:0] esum, input logic ecar);
    int   n;
    exp_t e;
    wait_ready();
    bus.start_in = 1'b1;
    bus.a_in     = a;
    bus.b_in     = b;
    bus.sub_in   = sub;
    e.sum = esum;
    e.car = ecar;
    e.cyc = cyc + 1 + WIDTH;
    exp_q.push_back(e);
    @(posedge clk_in);
    @(negedge clk_in);
    bus.start_in = 1'b0;
    bus.a_in     = WIDTH'($urandom);
    bus.b_in     = WIDTH'($urandom);
    n = 0;
    while (bus.ready_out !== 1'b1 && n < 50) begin
      n++;
      if (n == 3) begin
        check("busy_in_shift", 32'(bus.busy_out), 32'd1);
        check("hold_sum", 32'(bus.sum_out), 32'(last_sum));
        check("hold_car", 32'(bus.car_out), 32'(last_car));
      end
      @(negedge clk_in);
    end
    check("ready_low_cycles", n, WIDTH + 1);
    check("queue_drained", exp_q.size(), 0);
    last_sum = esum;
    last_car = ecar;
  endtask

  initial begin
    int   c0;
    int   n;
    exp_t e;
    bus.start_in = 1'b0;
    bus.a_in     = '0;
    bus.b_in     = '0;
    bus.sub_in   = 1'b0;

    repeat (2) @(negedge clk_in);
    check("rst_ready", 32'(bus.ready_out), 32'd1);
    check("rst_busy",  32'(bus.busy_out),  32'd0);
    check("rst_done",  32'(bus.done_out),  32'd0);
    check("rst_sum",   32'(bus.sum_out),   32'd0);
    check("rst_car",   32'(bus.car_out),   32'd0);
    rst_n_in = 1'b1;
    @(negedge clk_in);

    do_op(8'h5A, 8'h25, 1'b0, 8'h7F, 1'b0);
    do_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    do_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
    do_op(8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0);
`ifdef SERIAL_ADD_SUB_EN
    do_op(8'h10, 8'h01, 1'b1, 8'h0F, 1'b1);
    do_op(8'h01, 8'h02, 1'b1, 8'hFF, 1'b0);
`else
    do_op(8'h10, 8'h01, 1'b1, 8'h11, 1'b0);
`endif

    // Reset during SHIFT bit 4: abort with cleared outputs and no done pulse
    wait_ready();
    bus.start_in = 1'b1;
    bus.a_in     = 8'h12;
    bus.b_in     = 8'h34;
    bus.sub_in   = 1'b0;
    @(posedge clk_in);
    @(negedge clk_in);
    bus.start_in = 1'b0;
    repeat (4) @(negedge clk_in);
    check("abort_busy_before", 32'(bus.busy_out), 32'd1);
    rst_n_in = 1'b0;
    #1;
    check("abort_ready", 32'(bus.ready_out), 32'd1);
    check("abort_busy",  32'(bus.busy_out),  32'd0);
    check("abort_done",  32'(bus.done_out),  32'd0);
    check("abort_sum",   32'(bus.sum_out),   32'd0);
    check("abort_car",   32'(bus.car_out),   32'd0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    @(negedge clk_in);
    last_sum = '0;
    last_car = 1'b0;
    do_op(8'h03, 8'h04, 1'b0, 8'h07, 1'b0);

    // start held high: operand changes mid-op ignored, accepts every WIDTH+2 cycles
    wait_ready();
    c0 = cyc + 1;
    bus.start_in = 1'b1;
    bus.a_in     = 8'h01;
    bus.b_in     = 8'h01;
    bus.sub_in   = 1'b0;
    e.sum = 8'h02; e.car = 1'b0; e.cyc = c0 + WIDTH;      exp_q.push_back(e);
    e.sum = 8'h30; e.car = 1'b0; e.cyc = c0 + WIDTH + 10; exp_q.push_back(e);
    e.sum = 8'h10; e.car = 1'b1; e.cyc = c0 + WIDTH + 20; exp_q.push_back(e);
    @(posedge clk_in);
    @(negedge clk_in);
    bus.a_in = 8'h10;
    bus.b_in = 8'h20;
    repeat (10) @(negedge clk_in);
    bus.a_in = 8'hF0;
    bus.b_in = 8'h20;
    repeat (10) @(negedge clk_in);
    bus.start_in = 1'b0;
    bus.a_in     = '0;
    bus.b_in     = '0;

    n = 0;
    while ((exp_q.size() != 0 || bus.ready_out !== 1'b1) && n < 100) begin
      @(negedge clk_in);
      n++;
    end
    check("final_drain", exp_q.size(), 0);
    repeat (3) @(negedge clk_in);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end
endmodule
